// File: rtl/flit_packetizer.sv
// Packs a header byte plus six payload bytes into 64-bit flits and queues them
// in a first-word-fall-through FIFO with a valid/ready output handshake.
module flit_packetizer #(
    parameter int NODE_ID    = 0,
    parameter int N_DEST     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [63:0] flit_out,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic [15:0] drop_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [2:0]    DEST_MASK = 3'(N_DEST - 1);
    localparam logic [2:0]    SRC_ID    = 3'(NODE_ID);
    localparam logic [2:0]    LAST_IDX  = 3'd5;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    idx;
    logic [7:0]    seq;
    logic [2:0]    dest_q;
    logic [47:0]   asm_q;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          accept;
    logic          pop;
    logic          space;
    logic          push;
    logic [47:0]   push_payload;
    logic [63:0]   push_flit;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [63:0] pack_flit(input logic [2:0]  dest,
                                              input logic [7:0]  sq,
                                              input logic [47:0] payload);
        return {1'b1, dest, SRC_ID, sq, 1'b0, payload};
    endfunction

    assign flit_valid = rst & (count != '0);
    assign flit_out   = flit_valid ? mem[rd_ptr] : 64'h0;
    assign pop        = flit_valid & flit_ready;
    // A pop on the same edge frees a slot, so a full FIFO can still take a push.
    assign space      = (count < FULL_CNT) | pop;
    assign byte_ready = rst & (state != HOLD);
    assign accept     = byte_valid & byte_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= HEAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HEAD: if (accept) state_nxt = BODY;
            BODY: if (accept && idx == LAST_IDX) state_nxt = space ? HEAD : HOLD;
            HOLD: if (space) state_nxt = HEAD;
            default: state_nxt = HEAD;
        endcase
    end

    // The sixth payload byte bypasses the assembly register when it can be pushed at once.
    always_comb begin
        push         = 1'b0;
        push_payload = asm_q;
        case (state)
            BODY: begin
                if (accept && idx == LAST_IDX && space) begin
                    push         = 1'b1;
                    push_payload = {asm_q[39:0], byte_in};
                end
            end
            HOLD:    push = space;
            default: push = 1'b0;
        endcase
        push_flit = pack_flit(dest_q, seq, push_payload);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx      <= 3'd0;
            seq      <= 8'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= 16'd0;
        end else begin
            if (accept && state == HEAD)
                idx <= 3'd0;
            else if (accept && state == BODY && idx != LAST_IDX)
                idx <= idx + 3'd1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 8'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (byte_valid && !byte_ready)
                drop_cnt <= sat_inc16(drop_cnt);
        end
    end

    // Datapath storage carries no reset; validity is tracked by the control state.
    always_ff @(posedge clk) begin
        if (accept && state == HEAD)
            dest_q <= byte_in[2:0] & DEST_MASK;
        if (accept && state == BODY)
            asm_q <= {asm_q[39:0], byte_in};
        if (push)
            mem[wr_ptr] <= push_flit;
    end

endmodule

// File: tb/tb_flit_packetizer.sv
// Randomised bench for flit_packetizer: a queue-based reference model of the
// byte stream, flit FIFO and drop counter is compared against the DUT each cycle.
module tb_flit_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h0;
    logic        byte_valid = 1'b0;
    logic        flit_ready = 1'b0;

    logic        r1, v1, r2, v2;
    logic [63:0] f1, f2;
    logic [15:0] d1, d2;

    always #5 clk = ~clk;

    flit_packetizer #(.NODE_ID(1), .N_DEST(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(r1), .flit_out(f1), .flit_valid(v1), .flit_ready(flit_ready),
        .drop_cnt(d1)
    );

    flit_packetizer #(.NODE_ID(5), .N_DEST(2), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(r2), .flit_out(f2), .flit_valid(v2), .flit_ready(flit_ready),
        .drop_cnt(d2)
    );

    int total = 0;
    int bad   = 0;
    bit sel   = 1'b0;

    logic        o_ready, o_valid;
    logic [63:0] o_flit;
    logic [15:0] o_drop;
    always_comb begin
        o_ready = sel ? r2 : r1;
        o_valid = sel ? v2 : v1;
        o_flit  = sel ? f2 : f1;
        o_drop  = sel ? d2 : d1;
    end

    // Reference model state
    int          m_node  = 1;
    int          m_depth = 4;
    logic [2:0]  m_mask  = 3'd3;
    logic [7:0]  m_bytes[$];
    logic [7:0]  m_held_bytes[$];
    logic [63:0] m_fifo[$];
    bit          m_held = 1'b0;
    logic [7:0]  m_seq  = 8'd0;
    logic [15:0] m_drop = 16'd0;

    function automatic logic [63:0] m_build(input logic [7:0] h, input logic [47:0] pl,
                                            input logic [7:0] sq);
        logic [2:0] src;
        src = 3'(m_node);
        return {1'b1, h[2:0] & m_mask, src, sq, 1'b0, pl};
    endfunction

    function automatic logic        exp_ready(); return rst && !m_held; endfunction
    function automatic logic        exp_valid(); return rst && (m_fifo.size() > 0); endfunction
    function automatic logic [63:0] exp_flit();  return exp_valid() ? m_fifo[0] : 64'h0; endfunction

    task automatic m_push_bytes(input logic [7:0] q[$]);
        logic [47:0] pl;
        pl = 48'h0;
        for (int i = 1; i < 7; i++) pl = {pl[39:0], q[i]};
        m_fifo.push_back(m_build(q[0], pl, m_seq));
        m_seq = m_seq + 8'd1;
    endtask

    task automatic model_step();
        bit pop, space;
        if (!rst) begin
            m_bytes.delete(); m_held_bytes.delete(); m_fifo.delete();
            m_held = 1'b0; m_seq = 8'd0; m_drop = 16'd0;
            return;
        end
        pop   = (m_fifo.size() > 0) && flit_ready;
        space = (m_fifo.size() < m_depth) || pop;
        if (pop) void'(m_fifo.pop_front());
        if (byte_valid && m_held && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        if (m_held) begin
            if (space) begin
                m_push_bytes(m_held_bytes);
                m_held = 1'b0;
            end
        end else if (byte_valid) begin
            m_bytes.push_back(byte_in);
            if (m_bytes.size() == 7) begin
                if (space) m_push_bytes(m_bytes);
                else begin
                    m_held_bytes = m_bytes;
                    m_held = 1'b1;
                end
                m_bytes.delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic rs, input logic bv, input logic [7:0] b, input logic fr);
        rst = rs; byte_valid = bv; byte_in = b; flit_ready = fr;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 8'hA5, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({o_ready, o_valid, o_flit, o_drop} !== {1'b0, 1'b0, 64'h0, 16'h0}) begin
                bad++;
                $display("FAIL reset_outputs got ready=%b valid=%b flit=%h drop=%h want 0/0/0/0",
                         o_ready, o_valid, o_flit, o_drop);
            end
            tick();
        end
        rst = 1'b1;
    endtask

    task automatic test_single_flit();
        logic [7:0] pat [7];
        pat = '{8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, pat[i], 1'b1);
            #1;
            total++;
            if ({o_ready, o_valid, o_flit, o_drop} !== {exp_ready(), exp_valid(), exp_flit(), m_drop}) begin
                bad++;
                $display("FAIL t1_cycle%0d got %b/%b/%h/%h want %b/%b/%h/%h", i,
                         o_ready, o_valid, o_flit, o_drop, exp_ready(), exp_valid(), exp_flit(), m_drop);
            end
            tick();
        end
        byte_valid = 1'b0;
        #1;
        total++;
        if ({o_valid, o_flit} !== {1'b1, 64'hB200_1122_3344_5566}) begin
            bad++;
            $display("FAIL t1_flit got valid=%b flit=%h want 1/b200112233445566", o_valid, o_flit);
        end
        tick();
    endtask

    task automatic test_fill_hold();
        do_reset();
        for (int i = 0; i < 38; i++) begin
            drive(1'b1, 1'b1, 8'($urandom), 1'b0);
            #1;
            total++;
            if ({o_ready, o_valid, o_flit, o_drop} !== {exp_ready(), exp_valid(), exp_flit(), m_drop}) begin
                bad++;
                $display("FAIL t2_cycle%0d got %b/%b/%h/%h want %b/%b/%h/%h", i,
                         o_ready, o_valid, o_flit, o_drop, exp_ready(), exp_valid(), exp_flit(), m_drop);
            end
            tick();
            if (i == 34) begin
                #1;
                total++;
                if ({o_ready, o_valid, o_flit[56:49]} !== {1'b0, 1'b1, 8'd0}) begin
                    bad++;
                    $display("FAIL t2_hold got ready=%b valid=%b seq=%0d want 0/1/0",
                             o_ready, o_valid, o_flit[56:49]);
                end
            end
        end
        byte_valid = 1'b0;
        #1;
        total++;
        if (o_drop !== 16'd3) begin
            bad++;
            $display("FAIL t2_drop got %0d want 3", o_drop);
        end
    endtask

    task automatic test_push_pop_full();
        int nv;
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        #1;
        total++;
        if (o_flit[56:49] !== 8'd0) begin
            bad++;
            $display("FAIL t3_head_seq got %0d want 0", o_flit[56:49]);
        end
        tick();
        flit_ready = 1'b0;
        #1;
        total++;
        if ({o_ready, o_valid, o_flit, o_drop} !== {1'b1, exp_valid(), exp_flit(), m_drop}) begin
            bad++;
            $display("FAIL t3_after got %b/%b/%h/%h want 1/%b/%h/%h",
                     o_ready, o_valid, o_flit, o_drop, exp_valid(), exp_flit(), m_drop);
        end
        nv = 0;
        flit_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (o_valid) begin
                total++;
                if (o_flit[56:49] !== 8'(nv + 1)) begin
                    bad++;
                    $display("FAIL t3_drain_seq got %0d want %0d", o_flit[56:49], nv + 1);
                end
                nv++;
            end
            tick();
        end
        total++;
        if (nv != 4) begin
            bad++;
            $display("FAIL t3_drain_count got %0d want 4", nv);
        end
    endtask

    task automatic test_seq_wrap();
        int npop;
        do_reset();
        #1;
        total++;
        if (o_drop !== 16'd0) begin
            bad++;
            $display("FAIL t4_reset_drop got %0d want 0", o_drop);
        end
        npop = 0;
        for (int i = 0; i < 2104; i++) begin
            drive(1'b1, i < 2100, 8'($urandom), 1'b1);
            #1;
            total++;
            if ({o_ready, o_valid, o_flit, o_drop} !== {exp_ready(), exp_valid(), exp_flit(), m_drop}) begin
                bad++;
                $display("FAIL t4_cycle%0d got %b/%b/%h/%h want %b/%b/%h/%h", i,
                         o_ready, o_valid, o_flit, o_drop, exp_ready(), exp_valid(), exp_flit(), m_drop);
            end
            if (o_valid) begin
                total++;
                if (o_flit[56:49] !== 8'(npop)) begin
                    bad++;
                    $display("FAIL t4_order got seq=%0d want %0d", o_flit[56:49], npop % 256);
                end
                npop++;
            end
            tick();
        end
        total++;
        if (npop != 300 || o_drop !== 16'd0) begin
            bad++;
            $display("FAIL t4_totals got flits=%0d drop=%0d want 300/0", npop, o_drop);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(1'b1, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
            #1;
            total++;
            if ({o_ready, o_valid, o_flit, o_drop} !== {exp_ready(), exp_valid(), exp_flit(), m_drop}) begin
                bad++;
                $display("FAIL rand_cycle%0d got %b/%b/%h/%h want %b/%b/%h/%h", i,
                         o_ready, o_valid, o_flit, o_drop, exp_ready(), exp_valid(), exp_flit(), m_drop);
            end
            tick();
        end
    endtask

    task automatic test_mid_flit_reset();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 8'($urandom), 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        #1;
        total++;
        if ({o_ready, o_valid, o_flit} !== {1'b0, 1'b0, 64'h0}) begin
            bad++;
            $display("FAIL t5_during_reset got ready=%b valid=%b flit=%h want 0/0/0",
                     o_ready, o_valid, o_flit);
        end
        tick();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        total++;
        if ({o_valid, o_flit, o_drop} !== {1'b0, 64'h0, 16'h0}) begin
            bad++;
            $display("FAIL t5_after_reset got valid=%b flit=%h drop=%h want 0/0/0",
                     o_valid, o_flit, o_drop);
        end
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 8'($urandom), 1'b0);
            #1;
            total++;
            if ({o_ready, o_valid, o_flit, o_drop} !== {exp_ready(), exp_valid(), exp_flit(), m_drop}) begin
                bad++;
                $display("FAIL t5_cycle%0d got %b/%b/%h/%h want %b/%b/%h/%h", i,
                         o_ready, o_valid, o_flit, o_drop, exp_ready(), exp_valid(), exp_flit(), m_drop);
            end
            tick();
        end
        byte_valid = 1'b0;
        #1;
        total++;
        if ({o_valid, o_flit[56:49]} !== {1'b1, 8'd0}) begin
            bad++;
            $display("FAIL t5_seq_restart got valid=%b seq=%0d want 1/0", o_valid, o_flit[56:49]);
        end
    endtask

    task automatic test_dest_mask_saturate();
        sel = 1'b1; m_node = 5; m_depth = 2; m_mask = 3'd1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, (i == 0) ? 8'hFF : 8'($urandom), 1'b0);
            tick();
        end
        byte_valid = 1'b0;
        #1;
        total++;
        if ({o_valid, o_flit[62:60], o_flit[59:57], o_flit} !== {1'b1, 3'd1, 3'd5, exp_flit()}) begin
            bad++;
            $display("FAIL t6_dest got valid=%b flit=%h want dest=1 src=5 flit=%h",
                     o_valid, o_flit, exp_flit());
        end
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b1, 8'($urandom), 1'b0);
            tick();
        end
        #1;
        total++;
        if ({o_ready, o_drop} !== {1'b0, 16'd0}) begin
            bad++;
            $display("FAIL t6_hold got ready=%b drop=%0d want 0/0", o_ready, o_drop);
        end
        for (int i = 0; i < 65540; i++) begin
            tick();
            if (i == 65529) begin
                #1;
                total++;
                if (o_drop !== 16'd65530) begin
                    bad++;
                    $display("FAIL t6_drop_count got %0d want 65530", o_drop);
                end
            end
        end
        #1;
        total++;
        if ({o_drop, m_drop} !== {16'hFFFF, 16'hFFFF}) begin
            bad++;
            $display("FAIL t6_drop_sat got %h want ffff (model %h)", o_drop, m_drop);
        end
        sel = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_flit();
        test_fill_hold();
        test_push_pop_full();
        test_seq_wrap();
        test_random();
        test_mid_flit_reset();
        test_dest_mask_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
